laa_issue_queue: RTL and testbench

Buffers LAA custom instructions (opcode 7'b0001011) from the core's decode stage together with their captured rs1/rs2 operands. Issues them one at a time to LAA_core, which sits directly downstream. Holds a MULTIPLY on LAA_core's input for the whole busy interval, so LAA_core's polling of LAA register 31 can complete. Back-pressures decode through `in_ready` when the queue is full.

---
 rtl/laa_pkg.sv | 37 +++
 rtl/laa_iq_fifo.sv | 43 ++++
 rtl/laa_issue_queue.sv | 134 +++++++++++++
 tb/tb_laa_issue_queue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laa_pkg.sv
// rtl/laa_pkg.sv - shared LAA opcode, funct, state and queue entry definitions
package laa_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    READ     = 2'd1,
    WRITE    = 2'd2,
    MULTIPLY = 2'd3
  } LAA_opcode;

  localparam logic [6:0] LAA_CUSTOM_OPCODE = 7'b0001011;
  localparam logic [4:0] LAA_FUNCT_READ    = 5'b00001;
  localparam logic [4:0] LAA_FUNCT_WRITE   = 5'b00010;
  localparam logic [4:0] LAA_FUNCT_MUL     = 5'b00011;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_ARM  = 2'd1,
    S_MUL_BUSY = 2'd2
  } laa_iq_state_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } laa_iq_entry_t;

  function automatic LAA_opcode funct_to_op(input logic [4:0] funct);
    case (funct)
      LAA_FUNCT_READ:  return READ;
      LAA_FUNCT_WRITE: return WRITE;
      LAA_FUNCT_MUL:   return MULTIPLY;
      default:         return NONE;
    endcase
  endfunction

endpackage

// File: rtl/laa_iq_fifo.sv
// rtl/laa_iq_fifo.sv - power-of-two entry FIFO with wrap pointers, occupancy count and flush
module laa_iq_fifo
  import laa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  laa_iq_entry_t push_data,
  input  logic          pop,
  output laa_iq_entry_t head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  laa_iq_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/laa_issue_queue.sv
// rtl/laa_issue_queue.sv - LAA instruction issue queue and MULTIPLY hold FSM
// LAA_IQ_BYPASS_EN: empty-queue instructions skip storage and issue one cycle after acceptance.
module laa_issue_queue
  import laa_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ARM_TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       Rst,
  input  logic                       in_valid,
  input  logic [31:0]                in_ins,
  input  logic [31:0]                in_rs1_data,
  input  logic [31:0]                in_rs2_data,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       laa_busy,
  output logic [31:0]                LAA_ins,
  output logic [31:0]                IF_ID_dout_rs1,
  output logic [31:0]                IF_ID_dout_rs2,
  output logic                       out_valid,
  output logic                       mul_inflight,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_pulse
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

  laa_iq_state_t state, state_n;
  laa_iq_entry_t cur_q, out_n, head, new_entry;
  logic          valid_q, valid_n;
  logic [TW-1:0] arm_cnt, arm_cnt_n;
  logic          err_q, err_n;
  logic          accept, legal, push_ok, bypass, fifo_push, fifo_pop, issue_ok;

  assign in_ready  = !Rst && (count < CW'(DEPTH));
  assign accept    = in_valid && in_ready && (in_ins[6:0] == LAA_CUSTOM_OPCODE);
  assign legal     = funct_to_op(in_ins[11:7]) != NONE;
  assign push_ok   = accept && legal;
  assign new_entry = '{ins: in_ins, rs1: in_rs1_data, rs2: in_rs2_data};

`ifdef LAA_IQ_BYPASS_EN
  assign bypass = push_ok && (state == S_IDLE) && (count == '0) && !laa_busy && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = push_ok && !flush && !bypass;
  assign issue_ok  = (state == S_IDLE) && (count != '0) && !laa_busy && !flush;

  laa_iq_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst       (Rst),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (new_entry),
    .pop       (fifo_pop),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    state_n   = state;
    out_n     = '0;
    valid_n   = 1'b0;
    arm_cnt_n = arm_cnt;
    err_n     = accept && !legal;
    fifo_pop  = 1'b0;
    case (state)
      S_IDLE: begin
        arm_cnt_n = '0;
        if (bypass) begin
          out_n   = new_entry;
          valid_n = 1'b1;
        end else if (issue_ok) begin
          fifo_pop = 1'b1;
          out_n    = head;
          valid_n  = 1'b1;
        end
        if (valid_n && funct_to_op(out_n.ins[11:7]) == MULTIPLY) state_n = S_MUL_ARM;
      end
      S_MUL_ARM: begin
        out_n   = cur_q;
        valid_n = 1'b1;
        if (laa_busy) begin
          state_n = S_MUL_BUSY;
        end else if (arm_cnt == TW'(ARM_TIMEOUT - 1)) begin
          // LAA_core never acknowledged: abandon the MULTIPLY and flag it.
          err_n   = 1'b1;
          out_n   = '0;
          valid_n = 1'b0;
          state_n = S_IDLE;
        end else begin
          arm_cnt_n = arm_cnt + TW'(1);
        end
      end
      S_MUL_BUSY: begin
        out_n   = cur_q;
        valid_n = 1'b1;
        if (!laa_busy) begin
          out_n   = '0;
          valid_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state   <= S_IDLE;
      cur_q   <= '0;
      valid_q <= 1'b0;
      arm_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cur_q   <= out_n;
      valid_q <= valid_n;
      arm_cnt <= arm_cnt_n;
      err_q   <= err_n;
    end
  end

  assign LAA_ins        = cur_q.ins;
  assign IF_ID_dout_rs1 = cur_q.rs1;
  assign IF_ID_dout_rs2 = cur_q.rs2;
  assign out_valid      = valid_q;
  assign mul_inflight   = (state != S_IDLE);
  assign err_pulse      = err_q;

endmodule

// File: tb/tb_laa_issue_queue.sv
// tb/tb_laa_issue_queue.sv - directed and randomized bench for laa_issue_queue with a queue-based reference model
module tb_laa_issue_queue;

  localparam int DEPTH       = 4;
  localparam int ARM_TIMEOUT = 8;
  localparam logic [31:0] MUL_W  = 32'h0000_018B;
  localparam logic [31:0] READ_W = 32'h0440_008B;
  localparam logic [31:0] WR_W   = 32'h0880_010B;
  localparam logic [31:0] ILL_W  = 32'h0000_038B;

  logic        clk = 1'b0;
  logic        Rst, in_valid, flush, laa_busy;
  logic [31:0] in_ins, in_rs1_data, in_rs2_data;
  logic        in_ready, out_valid, mul_inflight, err_pulse;
  logic [31:0] LAA_ins, IF_ID_dout_rs1, IF_ID_dout_rs2;
  logic [2:0]  count;

  always #5 clk = ~clk;

  laa_issue_queue #(.DEPTH(DEPTH), .ARM_TIMEOUT(ARM_TIMEOUT)) dut (
    .clk            (clk),
    .Rst            (Rst),
    .in_valid       (in_valid),
    .in_ins         (in_ins),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_ready       (in_ready),
    .flush          (flush),
    .laa_busy       (laa_busy),
    .LAA_ins        (LAA_ins),
    .IF_ID_dout_rs1 (IF_ID_dout_rs1),
    .IF_ID_dout_rs2 (IF_ID_dout_rs2),
    .out_valid      (out_valid),
    .mul_inflight   (mul_inflight),
    .count          (count),
    .err_pulse      (err_pulse)
  );

  int vectors = 0;
  int miscompares = 0;
  int held, inflight, errs;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } ent_t;

  ent_t mq[$];
  ent_t mcur;
  bit   mvalid, merr;
  int   mphase;
  int   mage;

  function automatic ent_t zero_ent();
    ent_t z;
    z.ins = '0; z.rs1 = '0; z.rs2 = '0;
    return z;
  endfunction

  // Reference: a plain queue plus "what is on the wire" and "how long has the MULTIPLY waited".
  task automatic model_edge();
    bit acc, legal, byp;
    int f;
    ent_t e;
    if (Rst) begin
      mq.delete();
      mcur = zero_ent(); mvalid = 0; merr = 0; mphase = 0; mage = 0;
      return;
    end
    merr  = 0;
    f     = int'(in_ins[11:7]);
    acc   = in_valid && (mq.size() < DEPTH) && (in_ins[6:0] == 7'b0001011);
    legal = (f >= 1) && (f <= 3);
    if (acc && !legal) merr = 1;
    e.ins = in_ins; e.rs1 = in_rs1_data; e.rs2 = in_rs2_data;
    byp = 0;
`ifdef LAA_IQ_BYPASS_EN
    byp = acc && legal && (mphase == 0) && (mq.size() == 0) && !laa_busy && !flush;
`endif
    if (mphase == 0) begin
      mcur = zero_ent(); mvalid = 0;
      if (byp) begin
        mcur = e; mvalid = 1;
      end else if (mq.size() > 0 && !laa_busy && !flush) begin
        mcur = mq.pop_front(); mvalid = 1;
      end
      if (mvalid && mcur.ins[11:7] == 5'd3) begin mphase = 1; mage = 0; end
    end else if (mphase == 1) begin
      if (laa_busy) mphase = 2;
      else begin
        mage++;
        if (mage == ARM_TIMEOUT) begin merr = 1; mcur = zero_ent(); mvalid = 0; mphase = 0; end
      end
    end else if (!laa_busy) begin
      mcur = zero_ent(); mvalid = 0; mphase = 0;
    end
    if (flush) mq.delete();
    else if (acc && legal && !byp) mq.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("m_LAA_ins", LAA_ins, mcur.ins);
    chk("m_rs1", IF_ID_dout_rs1, mcur.rs1);
    chk("m_rs2", IF_ID_dout_rs2, mcur.rs2);
    chk("m_out_valid", 32'(out_valid), 32'(mvalid));
    chk("m_mul_inflight", 32'(mul_inflight), 32'(mphase != 0));
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_in_ready", 32'(in_ready), 32'(!Rst && mq.size() < DEPTH));
    chk("m_err_pulse", 32'(err_pulse), 32'(merr));
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input bit fl, input bit bsy);
    in_valid = v; in_ins = ins; in_rs1_data = r1; in_rs2_data = r2;
    flush = fl; laa_busy = bsy;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle(input int n, input bit bsy);
    repeat (n) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, bsy);
  endtask

  task automatic tally(input logic [31:0] word);
    if (out_valid === 1'b1 && LAA_ins === word) held++;
    if (mul_inflight === 1'b1) inflight++;
    if (err_pulse === 1'b1) errs++;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    int r;
    w = $urandom();
    r = $urandom_range(0, 9);
    if (r < 3)      w[11:7] = 5'd1;
    else if (r < 6) w[11:7] = 5'd2;
    else if (r < 8) w[11:7] = 5'd3;
    else            w[11:7] = 5'($urandom_range(4, 31));
    if ($urandom_range(0, 9) != 0) w[6:0] = 7'b0001011;
    return w;
  endfunction

  logic [31:0] fw [4];
  logic [31:0] w;
  bit          rbusy;

  initial begin
    Rst = 1'b1; in_valid = 0; in_ins = '0; in_rs1_data = '0; in_rs2_data = '0;
    flush = 0; laa_busy = 0;
    mq.delete(); mcur = zero_ent(); mvalid = 0; merr = 0; mphase = 0; mage = 0;

    idle(2, 1'b0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_LAA_ins", LAA_ins, 32'h0);
    Rst = 1'b0;
    idle(1, 1'b0);

    // Single WRITE
    step(1'b1, WR_W, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);
`ifdef LAA_IQ_BYPASS_EN
    chk("wr_issue", LAA_ins, WR_W);
    chk("wr_rs1", IF_ID_dout_rs1, 32'hDEAD_BEEF);
    idle(1, 1'b0);
`else
    chk("wr_not_yet", 32'(out_valid), 32'd0);
    idle(1, 1'b0);
    chk("wr_issue", LAA_ins, WR_W);
    chk("wr_rs1", IF_ID_dout_rs1, 32'hDEAD_BEEF);
`endif
    idle(1, 1'b0);
    chk("wr_one_cycle", 32'(out_valid), 32'd0);
    chk("wr_count", 32'(count), 32'd0);

    // Fill while busy, then drain in order
    for (int i = 0; i < 5; i++) begin
      w = 32'h0000_000B | (32'((i % 2 == 0) ? 2 : 1) << 7) | (32'(i) << 15);
      if (i < 4) fw[i] = w;
      step(1'b1, w, 32'(i), 32'(i + 100), 1'b0, 1'b1);
      if (i == 3) chk("fill_ready", 32'(in_ready), 32'd0);
    end
    chk("fill_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b0);
      chk("fill_order", LAA_ins, fw[i]);
    end
    idle(1, 1'b0);
    chk("fill_drained", 32'(count), 32'd0);

    // MULTIPLY handshake with a READ queued behind it
    held = 0; inflight = 0; errs = 0;
    step(1'b1, MUL_W, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0, 1'b0); tally(MUL_W);
    step(1'b1, READ_W, 32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0); tally(MUL_W);
    idle(1, 1'b0); tally(MUL_W);
    repeat (10) begin idle(1, 1'b1); tally(MUL_W); end
    idle(1, 1'b0);
    chk("mul_zero", 32'(out_valid), 32'd0);
`ifdef LAA_IQ_BYPASS_EN
    chk("mul_hold", 32'(held), 32'd13);
    chk("mul_inflight", 32'(inflight), 32'd13);
`else
    chk("mul_hold", 32'(held), 32'd12);
    chk("mul_inflight", 32'(inflight), 32'd12);
`endif
    idle(1, 1'b0);
    chk("mul_then_read", LAA_ins, READ_W);
    idle(1, 1'b0);

    // Arm timeout
    held = 0; inflight = 0; errs = 0;
    step(1'b1, MUL_W, 32'h1, 32'h2, 1'b0, 1'b0); tally(MUL_W);
    repeat (12) begin idle(1, 1'b0); tally(MUL_W); end
    chk("arm_err_count", 32'(errs), 32'd1);
    chk("arm_hold", 32'(held), 32'(ARM_TIMEOUT));
    chk("arm_idle", 32'(mul_inflight), 32'd0);

    // Illegal funct, then flush with a same-cycle push
    step(1'b1, ILL_W, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("ill_err", 32'(err_pulse), 32'd1);
    chk("ill_count", 32'(count), 32'd0);
    idle(1, 1'b0);
    chk("ill_err_width", 32'(err_pulse), 32'd0);
    repeat (3) step(1'b1, READ_W, 32'h7, 32'h8, 1'b0, 1'b1);
    chk("pre_flush_count", 32'(count), 32'd3);
    step(1'b1, WR_W, 32'h9, 32'hA, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    repeat (3) begin
      idle(1, 1'b0);
      chk("flush_no_issue", 32'(out_valid), 32'd0);
    end

    // Reset in the middle of a MULTIPLY
    step(1'b1, MUL_W, 32'h3, 32'h4, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b1, READ_W, 32'h5, 32'h6, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("pre_rst_inflight", 32'(mul_inflight), 32'd1);
    Rst = 1'b1;
    idle(1, 1'b1);
    chk("rst_mid_ins", LAA_ins, 32'h0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_inflight", 32'(mul_inflight), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    Rst = 1'b0;
    idle(1, 1'b0);

    // Push into an empty queue
    step(1'b1, WR_W, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
`ifdef LAA_IQ_BYPASS_EN
    chk("bypass_issue", LAA_ins, WR_W);
    chk("bypass_count", 32'(count), 32'd0);
`else
    chk("nobypass_wait", 32'(out_valid), 32'd0);
    idle(1, 1'b0);
    chk("nobypass_issue", LAA_ins, WR_W);
`endif
    idle(2, 1'b0);

    // Randomized traffic against the model
    rbusy = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) rbusy = !rbusy;
      Rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 1) == 1, rand_ins(), $urandom(), $urandom(),
           $urandom_range(0, 29) == 0, rbusy);
    end
    Rst = 1'b0;
    idle(20, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
